serializer_piso: RTL and testbench
==================================

SERIALIZER_PISO -- requirements
Module: serializer_piso

Interface
- REQ-001 The module SHALL have parameter W, default 8, meaning the parallel word width in bits, legal range 2..32.
- REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-004 The module SHALL have port up_valid, input, 1 bit: upstream word valid.
- REQ-005 The module SHALL have port up_ready, output, 1 bit: block can accept a word this cycle.
- REQ-006 The module SHALL have port up_data, input, W bits: parallel word, sampled on the upstream handshake.
- REQ-007 The module SHALL have port down_valid, output, 1 bit: down_data is a valid serial bit.
- REQ-008 The module SHALL have port down_ready, input, 1 bit: downstream consumes the current bit.
- REQ-009 The module SHALL have port down_data, output, 1 bit: current serial bit, selected from the stored word by a mux indexed by the bit counter.
- REQ-010 The module SHALL have port down_last, output, 1 bit: high with the final bit of a frame.

Function
- REQ-011 The FSM SHALL have two states. IDLE: no word held. SHIFT: word held, bits being emitted.
- REQ-012 The upstream handshake SHALL occur when up_valid && up_ready at a rising edge; up_data is latched and the bit index is cleared to 0.
- REQ-013 up_ready SHALL be 1 in IDLE; 1 in SHIFT only while the last bit of the frame is handshaking (down_valid && down_ready && down_last); 0 otherwise. This is a combinational path from down_ready to up_ready.
- REQ-014 Latency SHALL be one cycle: bit 0 appears on down_data with down_valid=1 in the cycle after the upstream handshake.
- REQ-015 Bits SHALL be emitted LSB first: beat k carries stored word bit k, k = 0..W-1.
- REQ-016 The bit index SHALL advance only on a downstream handshake (down_valid && down_ready).
- REQ-017 While down_ready=0, down_data, down_last and the index SHALL hold.
- REQ-018 On the last-bit handshake with no simultaneous upstream handshake, the FSM SHALL go SHIFT->IDLE and drop down_valid the next cycle.
- REQ-019 On the last-bit handshake with a simultaneous upstream handshake, the new word SHALL load, the FSM SHALL stay in SHIFT, and the new bit 0 SHALL appear the next cycle (no bubble).
- REQ-020 down_valid SHALL be 1 exactly in SHIFT. down_data and down_last SHALL be 0 in IDLE.
- REQ-021 up_data SHALL be ignored whenever no upstream handshake occurs; the stored word SHALL change only on a handshake.

Reset
- REQ-022 While rst=1 at a rising edge, the FSM SHALL go to IDLE and the index and stored word SHALL clear to 0.
- REQ-023 After reset: down_valid=0, down_data=0, down_last=0. up_ready SHALL be 0 while rst is high and 1 in the first cycle after.
- REQ-024 Reset in mid-frame SHALL abandon the frame; no remaining bit of it SHALL appear after reset.

Configuration
- REQ-025 With SERIALIZER_PARITY_EN defined, each frame SHALL be W+1 beats: W data bits, then one even-parity bit (XOR of the stored word); down_last SHALL be high only on the parity beat.
- REQ-026 Without SERIALIZER_PARITY_EN, each frame SHALL be W beats and down_last SHALL be high on data bit W-1.

Verification (W=8)
- REQ-027 Basic frame: send 8'hA5, down_ready=1 -> beats 1,0,1,0,0,1,0,1 on consecutive cycles starting one cycle after accept; down_last on beat 8; then down_valid=0.
- REQ-028 Back-to-back: send 8'h01, then 8'hFF held valid -> 8'hFF is accepted on the 8'h01 last beat; its bits follow with no idle cycle; up_ready=0 during other beats.
- REQ-029 Backpressure: send 8'h3C, hold down_ready=0 for 3 cycles at beat 2 -> down_data stays 1 (bit 2) for the stall; the full sequence 0,0,1,1,1,1,0,0 is intact.
- REQ-030 Reset mid-frame: send 8'hF0, assert rst at beat 3 -> next cycle down_valid=0 and up_ready=0; after rst drops, up_ready=1 and a new 8'h0F serializes correctly.
- REQ-031 Parity (SERIALIZER_PARITY_EN defined): send 8'h07 -> 9 beats, beat 9 = 1 with down_last; send 8'hA5 -> beat 9 = 0.
- REQ-032 Idle: up_valid=0 for 20 cycles -> down_valid stays 0 and up_ready stays 1.

Source files
------------

// File: rtl/serializer_piso.sv
// Parallel-in, serial-out converter with valid/ready on both sides, LSB first.
// Define SERIALIZER_PARITY_EN to append an even-parity beat to every frame.
module serializer_piso #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         down_valid,
  input  logic         down_ready,
  output logic         down_data,
  output logic         down_last
);

  // Index must reach W when the parity beat is present.
  localparam int unsigned IDX_W = $clog2(W + 1);
  localparam int unsigned SEL_W = $clog2(W);
`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned LAST_IDX = W;
`else
  localparam int unsigned LAST_IDX = W - 1;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             data_bit;
  logic             is_last;
  logic             dn_hs;
  logic             up_hs;

  assign is_last = (idx_q == IDX_W'(LAST_IDX));

`ifdef SERIALIZER_PARITY_EN
  assign data_bit = is_last ? ^word_q : word_q[idx_q[SEL_W-1:0]];
`else
  assign data_bit = word_q[idx_q[SEL_W-1:0]];
`endif

  assign down_valid = (state_q == SHIFT);
  assign down_data  = down_valid & data_bit;
  assign down_last  = down_valid & is_last;

  // A new word may enter while the final beat of the current frame leaves.
  assign dn_hs    = down_valid & down_ready;
  assign up_ready = ~rst & (~down_valid | (dn_hs & is_last));
  assign up_hs    = up_valid & up_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: load has priority, then frame end, then plain advance.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    if (up_hs) begin
      state_d = SHIFT;
      word_d  = up_data;
      idx_d   = '0;
    end else if (dn_hs && is_last) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (dn_hs) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_serializer_piso.sv
// Directed bench for serializer_piso (W=8); beat expectations are hand-written.
module tb_serializer_piso;

`ifdef SERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk;
  logic       rst;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] up_data;
  logic       down_valid;
  logic       down_ready;
  logic       down_data;
  logic       down_last;

  int n_chk;
  int n_fail;

  serializer_piso #(.W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_last  (down_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [0:7] beats;
    logic       par;
    int         stall_at;
    int         stall_len;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Checks NB beats of one frame; optional stall of stall_len cycles before beat stall_at.
  task automatic check_beats(input string tag, input logic [0:7] beats, input logic par,
                             input int stall_at, input int stall_len);
    logic eb;
    for (int k = 0; k < NB; k++) begin
      eb = (k < 8) ? beats[k] : par;
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          down_ready = 1'b0;
          #1;
          chk($sformatf("%s stall%0d valid", tag, s), down_valid, 1'b1);
          chk($sformatf("%s stall%0d data", tag, s), down_data, eb);
          chk($sformatf("%s stall%0d last", tag, s), down_last, (k == NB - 1));
          chk($sformatf("%s stall%0d up_ready", tag, s), up_ready, 1'b0);
          @(posedge clk);
          #1;
        end
        down_ready = 1'b1;
      end
      #1;
      chk($sformatf("%s beat%0d valid", tag, k), down_valid, 1'b1);
      chk($sformatf("%s beat%0d data", tag, k), down_data, eb);
      chk($sformatf("%s beat%0d last", tag, k), down_last, (k == NB - 1));
      chk($sformatf("%s beat%0d up_ready", tag, k), up_ready, (k == NB - 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " idle valid"}, down_valid, 1'b0);
    chk({tag, " idle data"}, down_data, 1'b0);
    chk({tag, " idle last"}, down_last, 1'b0);
    chk({tag, " idle up_ready"}, up_ready, 1'b1);
  endtask

  task automatic accept(input logic [7:0] d);
    up_valid = 1'b1;
    up_data  = d;
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    up_data  = ~d;
  endtask

  task automatic run_frame(input vec_t v);
    string tag;
    tag = $sformatf("frame %02h", v.data);
    accept(v.data);
    check_beats(tag, v.beats, v.par, v.stall_at, v.stall_len);
    check_idle(tag);
  endtask

  initial begin
    logic [0:7] b01, bff, bf0, b07, ba5;
    n_chk      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = 8'h00;
    down_ready = 1'b1;

    tbl[0] = '{data: 8'hA5, beats: 8'b10100101, par: 1'b0, stall_at: -1, stall_len: 0};
    tbl[1] = '{data: 8'h3C, beats: 8'b00111100, par: 1'b0, stall_at:  2, stall_len: 3};
    tbl[2] = '{data: 8'h80, beats: 8'b00000001, par: 1'b1, stall_at:  7, stall_len: 2};
    tbl[3] = '{data: 8'h07, beats: 8'b11100000, par: 1'b1, stall_at: -1, stall_len: 0};
    tbl[4] = '{data: 8'h01, beats: 8'b10000000, par: 1'b1, stall_at:  0, stall_len: 1};
    tbl[5] = '{data: 8'hFF, beats: 8'b11111111, par: 1'b0, stall_at: -1, stall_len: 0};
    b01 = 8'b10000000;
    bff = 8'b11111111;
    bf0 = 8'b00001111;
    b07 = 8'b11100000;
    ba5 = 8'b10100101;

    // Reset state
    @(posedge clk);
    #1;
    chk("reset up_ready", up_ready, 1'b0);
    chk("reset valid", down_valid, 1'b0);
    chk("reset data", down_data, 1'b0);
    chk("reset last", down_last, 1'b0);
    rst = 1'b0;
    #1;
    check_idle("post-reset");

    // Table-driven frames, some with backpressure
    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    // Back-to-back: 8'hFF held valid is taken on the last beat of 8'h01
    up_valid = 1'b1;
    up_data  = 8'h01;
    @(posedge clk);
    #1;
    up_data = 8'hFF;
    check_beats("b2b 01", b01, 1'b1, -1, 0);
    up_valid = 1'b0;
    up_data  = 8'h00;
    check_beats("b2b FF", bff, 1'b0, -1, 0);
    check_idle("b2b");

    // Reset in mid-frame at beat 3
    accept(8'hF0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst-mid beat%0d data", k), down_data, bf0[k]);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("rst-mid up_ready during rst", up_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("rst-mid valid", down_valid, 1'b0);
    chk("rst-mid up_ready", up_ready, 1'b0);
    chk("rst-mid data", down_data, 1'b0);
    rst = 1'b0;
    #1;
    check_idle("rst-mid");
    accept(8'h0F);
    check_beats("after-rst 0F", 8'b11110000, 1'b0, -1, 0);
    check_idle("after-rst");

`ifdef SERIALIZER_PARITY_EN
    accept(8'h07);
    check_beats("parity 07", b07, 1'b1, -1, 0);
    check_idle("parity 07");
    accept(8'hA5);
    check_beats("parity A5", ba5, 1'b0, -1, 0);
    check_idle("parity A5");
`else
    accept(8'h07);
    check_beats("plain 07", b07, 1'b1, -1, 0);
    check_idle("plain 07");
    accept(8'hA5);
    check_beats("plain A5", ba5, 1'b0, -1, 0);
    check_idle("plain A5");
`endif

    // Idle with changing up_data but no valid
    for (int c = 0; c < 20; c++) begin
      up_data = 8'(c * 37);
      @(posedge clk);
      #1;
      chk($sformatf("idle%0d valid", c), down_valid, 1'b0);
      chk($sformatf("idle%0d up_ready", c), up_ready, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
